// File: rtl/spi_sensor_poller_if.sv
// Handshake bundle between the sensor poller and the SPI master.
// The poller owns start/data_in; the SPI master owns busy/data_out.
interface spi_sensor_poller_if #(
  parameter int BITS = 16
);
  logic            spi_start_n;
  logic [BITS-1:0] spi_data_in;
  logic            spi_busy;
  logic [BITS-1:0] spi_data_out;

  modport master (
    output spi_start_n,
    output spi_data_in,
    input  spi_busy,
    input  spi_data_out
  );

  modport slave (
    input  spi_start_n,
    input  spi_data_in,
    output spi_busy,
    output spi_data_out
  );
endinterface

// File: rtl/spi_sensor_poller.sv
// Periodic SPI sensor poller: issues a fixed read command on every poll
// tick, captures the returned word, counts consecutive over-threshold
// samples into a sticky alarm and flags a hung master handshake.
module spi_sensor_poller #(
  parameter int              BITS       = 16,
  parameter logic [27:0]     POLL_DIV   = 28'd50_000_000,
  parameter logic [BITS-1:0] CMD        = BITS'(16'h8000),
  parameter logic [BITS-1:0] THRESH     = BITS'(16'd2048),
  parameter int              TRIP_COUNT = 3,
  parameter logic [27:0]     TIMEOUT    = 28'd2_000_000
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                alarm_clr,
  spi_sensor_poller_if.master spi,
  output logic [BITS-1:0]     sample,
  output logic                sample_valid,
  output logic                alarm,
  output logic                fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    CAPT = 2'd3
  } state_t;

  localparam logic [3:0] TRIP = 4'(TRIP_COUNT);

  state_t      state;
  state_t      state_nxt;
  logic [27:0] poll_cnt;
  logic [27:0] to_cnt;
  logic [3:0]  hits;
  logic        tick;
  logic        to_expired;
  logic        capt;
  logic        to_fire;
  logic        trip;
  logic        to_clear;
  logic [3:0]  hits_inc;

  // Hit counter increment that sticks at the trip count.
  function automatic logic [3:0] hit_sat_inc(input logic [3:0] h);
    if (h >= TRIP) return TRIP;
    return h + 4'd1;
  endfunction

  // Timeout counter increment that sticks at the timeout limit.
  function automatic logic [27:0] to_sat_inc(input logic [27:0] c);
    if (c >= TIMEOUT) return TIMEOUT;
    return c + 28'd1;
  endfunction

  assign tick       = (poll_cnt == 28'd0);
  // The incremented count reaches TIMEOUT on this edge.
  assign to_expired = (to_cnt >= (TIMEOUT - 28'd1));
  assign trip       = (spi.spi_data_out > THRESH);
  assign hits_inc   = hit_sat_inc(hits);
  assign to_clear   = ((state == IDLE) && (state_nxt == REQ)) ||
                      ((state == REQ)  && (state_nxt == XFER));

  // Free-running poll divider, independent of the sequencer.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)    poll_cnt <= POLL_DIV - 28'd1;
    else if (tick) poll_cnt <= POLL_DIV - 28'd1;
    else           poll_cnt <= poll_cnt - 28'd1;
  end

  // Sequencer state register.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sequencer next-state logic; ticks outside IDLE are simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tick && arm && !fault) state_nxt = REQ;
      REQ: begin
        if (spi.spi_busy)    state_nxt = XFER;
        else if (to_expired) state_nxt = IDLE;
      end
      XFER: begin
        if (!spi.spi_busy)   state_nxt = CAPT;
        else if (to_expired) state_nxt = IDLE;
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer outputs; start follows state so reset raises it asynchronously.
  always_comb begin
    spi.spi_start_n = 1'b1;
    spi.spi_data_in = CMD;
    capt            = 1'b0;
    to_fire         = 1'b0;
    case (state)
      REQ: begin
        spi.spi_start_n = 1'b0;
        to_fire         = !spi.spi_busy && to_expired;
      end
      XFER:    to_fire = spi.spi_busy && to_expired;
      CAPT:    capt    = 1'b1;
      default: ;
    endcase
  end

  // Per-phase handshake timeout counter, cleared on each phase entry.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)                               to_cnt <= 28'd0;
    else if (to_clear)                        to_cnt <= 28'd0;
    else if ((state == REQ) || (state == XFER)) to_cnt <= to_sat_inc(to_cnt);
  end

  // Sample capture; the valid pulse lines up with the captured word.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= capt;
      if (capt) sample <= spi.spi_data_out;
    end
  end

  // Hit counting, sticky alarm and fault; clear wins over a same-cycle capture.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      hits  <= 4'd0;
      alarm <= 1'b0;
      fault <= 1'b0;
    end else if (alarm_clr) begin
      hits  <= 4'd0;
      alarm <= 1'b0;
      fault <= 1'b0;
    end else begin
      if (to_fire) fault <= 1'b1;
      if (capt) begin
        if (trip) begin
          hits <= hits_inc;
          if (hits_inc == TRIP) alarm <= 1'b1;
        end else begin
          hits <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Bench for spi_sensor_poller: behavioural SPI slave plus a run-length
// reference model of the alarm rule, driven by directed and random polls.
module tb_spi_sensor_poller;

  localparam int          THR  = 2048;
  localparam int          TRIP = 3;
  localparam logic [15:0] CMDW = 16'h8000;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        alarm_clr;
  logic [15:0] sample;
  logic        sample_valid;
  logic        alarm;
  logic        fault;

  spi_sensor_poller_if #(.BITS(16)) spi_if ();

  spi_sensor_poller #(
    .BITS    (16),
    .POLL_DIV(28'd100),
    .TIMEOUT (28'd50)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .rst_n       (rst_n),
    .arm         (arm),
    .alarm_clr   (alarm_clr),
    .spi         (spi_if.master),
    .sample      (sample),
    .sample_valid(sample_valid),
    .alarm       (alarm),
    .fault       (fault)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_valid = 0;
  int last_fall = 0;
  int prev_fall = 0;
  logic start_q = 1'b1;
  int slave_mode = 0;          // 0 normal, 1 busy stuck low, 2 busy stuck high
  logic [15:0] resp_q[$];      // words the slave will return
  logic [15:0] sent_q[$];      // words the slave actually returned

  // reference model state: length of current run of over-threshold samples
  int   m_run = 0;
  logic m_alarm = 1'b0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (start_q && !spi_if.spi_start_n) begin
      n_starts  <= n_starts + 1;
      prev_fall <= last_fall;
      last_fall <= cyc;
    end
    if (sample_valid) n_valid <= n_valid + 1;
    start_q <= spi_if.spi_start_n;
  end

  // behavioural SPI master/slave: answers each start with a busy window
  initial begin : slave
    int s_phase;
    int s_cnt;
    logic [15:0] v;
    s_phase = 0;
    s_cnt = 0;
    spi_if.spi_busy = 1'b0;
    spi_if.spi_data_out = 16'h0000;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (slave_mode == 1) begin
        spi_if.spi_busy = 1'b0;
        s_phase = 0;
      end else if (slave_mode == 2) begin
        spi_if.spi_busy = 1'b1;
        s_phase = 0;
      end else begin
        case (s_phase)
          0: begin
            spi_if.spi_busy = 1'b0;
            if (!spi_if.spi_start_n) begin
              s_cnt = $urandom_range(0, 2);
              s_phase = 1;
            end
          end
          1: if (s_cnt == 0) begin
            spi_if.spi_busy = 1'b1;
            s_cnt = $urandom_range(8, 20);
            s_phase = 2;
          end else s_cnt--;
          2: if (s_cnt == 0) begin
            v = (resp_q.size() > 0) ? resp_q.pop_front() : 16'($urandom);
            spi_if.spi_data_out = v;
            sent_q.push_back(v);
            spi_if.spi_busy = 1'b0;
            s_phase = 3;
          end else s_cnt--;
          default: s_phase = 0;
        endcase
      end
    end
  end

  initial begin : watchdog
    #(20 * 60000);
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_run = 0;
    m_alarm = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge CLOCK_50);
    #1 alarm_clr = 1'b1;
    @(posedge CLOCK_50);
    #1 alarm_clr = 1'b0;
    model_clear();
    @(negedge CLOCK_50);
    check("clr_alarm", 32'(alarm), 0);
    check("clr_fault", 32'(fault), 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // wait for the next capture and compare against the reference model
  task automatic expect_poll(input string tag);
    int n;
    logic [15:0] v;
    n = 0;
    @(negedge CLOCK_50);
    while (sample_valid !== 1'b1 && n < 400) begin
      @(negedge CLOCK_50);
      n++;
    end
    check({tag, "_valid_seen"}, 32'(sample_valid), 1);
    if (sample_valid === 1'b1) begin
      check({tag, "_slave_word"}, 32'(sent_q.size() > 0), 1);
      v = (sent_q.size() > 0) ? sent_q.pop_front() : 16'hxxxx;
      if (int'(v) > THR) m_run++;
      else m_run = 0;
      if (m_run >= TRIP) m_alarm = 1'b1;
      check({tag, "_sample"}, 32'(sample), 32'(v));
      check({tag, "_alarm"}, 32'(alarm), 32'(m_alarm));
      @(negedge CLOCK_50);
      check({tag, "_valid_width"}, 32'(sample_valid), 0);
    end
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (spi_if.spi_busy !== 1'b1 && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    check({tag, "_busy_seen"}, 32'(spi_if.spi_busy), 1);
  endtask

  task automatic wait_fault(input string tag);
    int n;
    n = 0;
    while (fault !== 1'b1 && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    check({tag, "_fault_seen"}, 32'(fault), 1);
  endtask

  initial begin : main
    int n0;
    logic [15:0] rv;
    rst_n = 1'b0;
    arm = 1'b0;
    alarm_clr = 1'b0;

    // reset and idle
    repeat (3) @(posedge CLOCK_50);
    #1 rst_n = 1'b1;
    @(negedge CLOCK_50);
    check("rst_start_n", 32'(spi_if.spi_start_n), 1);
    check("rst_data_in", 32'(spi_if.spi_data_in), 32'(CMDW));
    check("rst_sample", 32'(sample), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_fault", 32'(fault), 0);
    wait_cycles(300);
    check("idle_no_start", 32'(n_starts), 0);
    check("idle_no_valid", 32'(n_valid), 0);
    check("idle_start_n", 32'(spi_if.spi_start_n), 1);
    check("idle_sample", 32'(sample), 0);

    // single polls and poll period
    resp_q.push_back(16'h0100);
    resp_q.push_back(16'h0100);
    arm = 1'b1;
    expect_poll("single1");
    expect_poll("single2");
    arm = 1'b0;
    check("poll_period", 32'(last_fall - prev_fall), 100);
    check("data_in_cmd", 32'(spi_if.spi_data_in), 32'(CMDW));

    // trip sequence: alarm only on the sixth sample
    foreach (resp_q[i]) resp_q.delete(i);
    resp_q.push_back(16'd2049);
    resp_q.push_back(16'd2049);
    resp_q.push_back(16'd100);
    resp_q.push_back(16'd2049);
    resp_q.push_back(16'd2049);
    resp_q.push_back(16'd2049);
    arm = 1'b1;
    for (int i = 0; i < 6; i++) expect_poll($sformatf("trip%0d", i));
    arm = 1'b0;
    check("trip_alarm_set", 32'(alarm), 1);
    pulse_clr();
    resp_q.push_back(16'd2049);
    arm = 1'b1;
    expect_poll("after_clr");
    arm = 1'b0;

    // randomized words clustered around the threshold
    pulse_clr();
    arm = 1'b1;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = 16'd2048;
        1:       rv = 16'd2049;
        2:       rv = 16'd2047;
        default: rv = 16'($urandom);
      endcase
      resp_q.push_back(rv);
      expect_poll($sformatf("rand%0d", i));
    end
    arm = 1'b0;

    // boundary: equal to threshold never trips, full scale does
    pulse_clr();
    for (int i = 0; i < 3; i++) resp_q.push_back(16'd2048);
    for (int i = 0; i < 3; i++) resp_q.push_back(16'hFFFF);
    arm = 1'b1;
    for (int i = 0; i < 6; i++) expect_poll($sformatf("bound%0d", i));
    arm = 1'b0;
    check("bound_alarm", 32'(alarm), 1);

    // reset in the middle of a transfer
    resp_q.push_back(16'h0042);
    arm = 1'b1;
    wait_busy("mid_rst");
    wait_cycles(2);
    #1 rst_n = 1'b0;
    #2;
    check("mid_rst_start_n", 32'(spi_if.spi_start_n), 1);
    check("mid_rst_sample", 32'(sample), 0);
    check("mid_rst_valid", 32'(sample_valid), 0);
    check("mid_rst_alarm", 32'(alarm), 0);
    check("mid_rst_fault", 32'(fault), 0);
    arm = 1'b0;
    wait_cycles(60);
    @(posedge CLOCK_50);
    #1 rst_n = 1'b1;
    sent_q.delete();
    model_clear();

    // busy never rises: fault from REQ after TIMEOUT cycles
    slave_mode = 1;
    arm = 1'b1;
    wait_fault("to_req");
    check("to_req_latency", 32'(cyc - last_fall), 50);
    n0 = n_starts;
    wait_cycles(300);
    check("to_req_no_poll", 32'(n_starts), 32'(n0));
    check("to_req_start_n", 32'(spi_if.spi_start_n), 1);

    // busy stuck high: polling resumes after clear, then faults from XFER
    slave_mode = 2;
    pulse_clr();
    wait_fault("to_xfer");
    check("to_xfer_resumed", 32'(n_starts > n0), 1);
    check("to_xfer_latency", 32'(cyc - last_fall), 51);
    arm = 1'b0;
    slave_mode = 0;
    pulse_clr();
    wait_cycles(5);

    // dropping arm mid-transfer lets the transfer finish, then stops
    resp_q.push_back(16'h1234);
    arm = 1'b1;
    wait_busy("arm_drop");
    arm = 1'b0;
    expect_poll("arm_drop");
    n0 = n_starts;
    wait_cycles(300);
    check("arm_drop_no_poll", 32'(n_starts), 32'(n0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sensor_poller.md
# spi_sensor_poller

Periodic transaction sequencer that sits directly upstream of the SPI master in the entry-alarm datapath. On every poll tick it drives a fixed read command into the master, handshakes on the master's active-low `start` and `busy`, captures the returned word, and compares it against a trip threshold. A hit counter then raises a sticky intrusion alarm. The block also watches the master for a hung handshake and reports a sticky fault.

## Interface
Parameters:
- `BITS`, 16, SPI word width; must equal the master's `bits_transfer`.
- `POLL_DIV`, 28'd50_000_000, poll period in CLOCK_50 cycles (1 s).
- `CMD`, 16'h8000, word driven on `spi_data_in` for every poll.
- `THRESH`, 16'd2048, unsigned trip level; a sample trips if `sample > THRESH`.
- `TRIP_COUNT`, 3, consecutive tripping samples needed to raise `alarm` (1..15).
- `TIMEOUT`, 28'd2_000_000, maximum cycles allowed per handshake phase.

Ports:
- `CLOCK_50`, in, 1, 50 MHz system clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `arm`, in, 1, 1 = polling enabled; 0 = finish the current transaction, then idle.
- `alarm_clr`, in, 1, synchronous clear of `alarm`, `fault` and the hit counter.
- `spi_start_n`, out, 1, connects to the master's `start` input (active low).
- `spi_data_in`, out, BITS, connects to the master's `data_in`.
- `spi_busy`, in, 1, the master's `busy`.
- `spi_data_out`, in, BITS, the master's `data_out`.
- `sample`, out, BITS, last captured word.
- `sample_valid`, out, 1, one-cycle pulse when `sample` updates.
- `alarm`, out, 1, sticky intrusion alarm.
- `fault`, out, 1, sticky handshake-timeout flag.

## Operation
Reset values:
- `spi_start_n` = 1, `spi_data_in` = `CMD`.
- `sample` = 0, `sample_valid` = 0, `alarm` = 0, `fault` = 0.
- Hit counter = 0, state = IDLE.
- Poll counter = `POLL_DIV`-1.

Poll counter:
- Free-running down-counter. `tick` is asserted when the counter is 0, and the counter reloads `POLL_DIV`-1.
- The tick period is exactly `POLL_DIV` cycles, independent of the state machine.

State machine:
- **IDLE**:
  - `spi_start_n` = 1.
  - On `tick && arm && !fault`, go to REQ and clear the timeout counter.
  - Ticks arriving outside IDLE are dropped.
- **REQ**:
  - `spi_start_n` = 0.
  - When `spi_busy` = 1, go to XFER and clear the timeout counter.
  - If the timeout counter reaches `TIMEOUT`, set `fault` and go to IDLE.
- **XFER**:
  - `spi_start_n` = 1.
  - When `spi_busy` = 0, go to CAPT.
  - On timeout, set `fault` and go to IDLE.
- **CAPT** (1 cycle), then go to IDLE:
  - `sample` <= `spi_data_out` and `sample_valid` = 1.
  - If `spi_data_out > THRESH`: hit counter saturating-increments to `TRIP_COUNT`, and `alarm` <= 1 when the incremented value equals `TRIP_COUNT`.
  - Otherwise the hit counter clears to 0. `alarm` is not cleared.

General rules:
- `spi_data_in` holds `CMD` constantly.
- `fault` = 1 blocks new polls until `alarm_clr`.
- `alarm_clr` has priority over a same-cycle CAPT update of `alarm` and of the hit counter. `sample` still updates in that cycle.
- Deasserting `arm` mid-transaction does not abort the transaction. CAPT still runs and the alarm logic still updates.
- The comparison is unsigned and full-width, BITS bits.
- Reset mid-transaction returns to reset values immediately. `spi_start_n` goes high asynchronously.

## Timing
- Tick to `spi_start_n` low: 1 cycle (registered).
- `spi_start_n` stays low from REQ entry until the first cycle `spi_busy` is sampled high, then rises on the next edge.
- The master samples `start` in its IDLE state, so a low level held for at least 1 cycle guarantees one transaction.
- `busy` falling edge to `sample_valid`: 1 cycle (CAPT). `sample_valid` is high for exactly 1 cycle.
- `alarm` rises in the same cycle as the `sample_valid` of the `TRIP_COUNT`-th consecutive hit.
- The timeout counter is 28 bits, counts only in REQ and XFER, and saturates at `TIMEOUT`.
- `POLL_DIV` must exceed one full master transaction plus 3 cycles. Otherwise ticks are dropped and the poll rate halves; this is a legal but unintended configuration.

## Test plan
1. **Reset and idle.** Reset, `arm` = 0 for 3·`POLL_DIV` cycles -> `spi_start_n` stays 1, no `sample_valid`, all outputs at reset values.
2. **Single poll.**
   - Setup: `POLL_DIV` = 100, `arm` = 1, real `spi_master` with `spi_clk_div` = 2, slave model returns 16'h0100.
   - Required: one `start` low pulse per 100 cycles, `sample_valid` pulses, `sample` = 16'h0100, `alarm` = 0.
3. **Trip sequence.**
   - Stimulus: slave returns 2049, 2049, 100, 2049, 2049, 2049.
   - Required: `alarm` rises on the 6th `sample_valid` only.
   - Then `alarm_clr` for 1 cycle -> `alarm` = 0 and the next single 2049 does not re-trip.
4. **Boundary.** Slave returns exactly 2048 three times -> no alarm. Returns 16'hFFFF three times -> alarm.
5. **Timeouts.**
   - Stub `spi_busy` stuck 0 with `TIMEOUT` = 50 -> `fault` = 1 exactly 50 cycles after REQ entry, no further `start` pulses.
   - `alarm_clr` resumes polling.
   - Repeat with `spi_busy` stuck 1 -> fault raised from XFER.
6. **Mid-transaction events.**
   - Assert `rst_n` = 0 during XFER -> `spi_start_n` = 1 and outputs reset immediately.
   - Drop `arm` during XFER -> the transaction completes, `sample_valid` fires, no further polls.
